// File: rtl/riscv_timer_unit_pkg.sv
// Shared definitions for the machine timer unit.
//  - regsel encodings for the three architected registers plus the reserved slot
//  - access size encodings (byte/half/word/double)
//  - ctrl register bit positions and reset constants
//  - lane_end(): one past the last byte lane touched by an aligned access
package riscv_timer_unit_pkg;

    typedef enum logic [1:0] {
        TIMER_MTIME    = 2'b00,
        TIMER_MTIMECMP = 2'b01,
        TIMER_CTRL     = 2'b10,
        TIMER_RSVD     = 2'b11
    } timer_regsel_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } timer_size_e;

    localparam int          CTRL_EN_BIT      = 0;
    localparam int          CTRL_DIV_LSB     = 1;
    localparam int          PRESCALE_W_DEF   = 16;
    localparam logic [63:0] MTIME_RST        = 64'h0;
    localparam logic [63:0] MTIMECMP_RST_DEF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic        CTRL_EN_RST      = 1'b1;

    // Offset 7 with a double would give 15; upstream guarantees alignment, so
    // the result never exceeds 8 for legal requests, but 4 bits avoids overflow.
    function automatic logic [3:0] lane_end(input logic [2:0] offset, input logic [1:0] size);
        return {1'b0, offset} + (4'd1 << size);
    endfunction

endpackage

// File: rtl/riscv_timer_unit_if.sv
// Timer port between the execute/memory stages (master) and the timer unit (slave).
//  i_riscv_timer_wren/rden  access requests
//  i_riscv_timer_regsel     register select
//  i_riscv_timer_offset     byte offset inside the 64-bit register
//  i_riscv_timer_size       access size
//  i_riscv_timer_wdata      right-aligned store data
//  o_riscv_timer_rdata      registered 64-bit read data
//  o_riscv_timer_rvalid     read data valid
interface riscv_timer_unit_if;
    logic        i_riscv_timer_wren;
    logic        i_riscv_timer_rden;
    logic [1:0]  i_riscv_timer_regsel;
    logic [2:0]  i_riscv_timer_offset;
    logic [1:0]  i_riscv_timer_size;
    logic [63:0] i_riscv_timer_wdata;
    logic [63:0] o_riscv_timer_rdata;
    logic        o_riscv_timer_rvalid;

    modport master (
        output i_riscv_timer_wren, i_riscv_timer_rden, i_riscv_timer_regsel,
               i_riscv_timer_offset, i_riscv_timer_size, i_riscv_timer_wdata,
        input  o_riscv_timer_rdata, o_riscv_timer_rvalid
    );

    modport slave (
        input  i_riscv_timer_wren, i_riscv_timer_rden, i_riscv_timer_regsel,
               i_riscv_timer_offset, i_riscv_timer_size, i_riscv_timer_wdata,
        output o_riscv_timer_rdata, o_riscv_timer_rvalid
    );
endinterface

// File: rtl/riscv_timer_unit_prescaler.sv
// Prescaler for mtime: counts enabled cycles and pulses tick when the count
// reaches div, then restarts from 0 (div=0 -> tick every enabled cycle).
//  clk, rst_n  clock and asynchronous active-low reset
//  en          count enable (en=0 freezes the count)
//  div         terminal count
//  clear       force the count back to 0 on the next edge
//  tick        combinational: mtime should advance on this edge
module riscv_timer_prescaler
    import riscv_timer_unit_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clear,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_reg;
    logic [PRESCALE_W-1:0] cnt_next;

    // tick uses the div/en currently held, so a ctrl write only changes the
    // rate from the following cycle.
    assign tick = en && (cnt_reg == div);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = tick ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/riscv_timer_unit.sv
// Memory-mapped machine timer (mtime, mtimecmp, ctrl) with registered reads
// and a level machine-timer interrupt.
//  i_riscv_timer_clk        clock
//  i_riscv_timer_rst        asynchronous active-low reset
//  i_riscv_timer_globstall  pipeline stall: port accesses are ignored, read outputs hold
//  bus                      timer port (slave side), see riscv_timer_unit_if
//  o_riscv_timer_irq        registered (mtime >= mtimecmp)
//  o_riscv_timer_mtime      current mtime register
module riscv_timer_unit
    import riscv_timer_unit_pkg::*;
#(
    parameter int          PRESCALE_W   = PRESCALE_W_DEF,
    parameter logic [63:0] MTIMECMP_RST = MTIMECMP_RST_DEF
) (
    input  logic               i_riscv_timer_clk,
    input  logic               i_riscv_timer_rst,
    input  logic               i_riscv_timer_globstall,
    riscv_timer_unit_if.slave  bus,
    output logic               o_riscv_timer_irq,
    output logic [63:0]        o_riscv_timer_mtime
);

    logic [63:0]           mtime_reg,    mtime_next;
    logic [63:0]           mtimecmp_reg, mtimecmp_next;
    logic                  ctrl_en_reg,  ctrl_en_next;
    logic [PRESCALE_W-1:0] ctrl_div_reg, ctrl_div_next;
    logic [63:0]           rdata_reg,    rdata_next;
    logic                  rvalid_reg,   rvalid_next;
    logic                  irq_reg,      irq_next;

    timer_regsel_e regsel;
    logic          wr_acc;
    logic          rd_acc;
    logic          tick;
    logic          cnt_clear;
    logic [3:0]    wr_end;
    logic [7:0]    lane_sel;
    logic [63:0]   wdata_shifted;
    logic [63:0]   sel_val;
    logic [63:0]   wr_merged;
    logic [63:0]   ctrl_val;

    assign regsel = timer_regsel_e'(bus.i_riscv_timer_regsel);
    assign wr_acc = bus.i_riscv_timer_wren && !i_riscv_timer_globstall;
    assign rd_acc = bus.i_riscv_timer_rden && !i_riscv_timer_globstall;

    // Unimplemented ctrl bits read as zero.
    assign ctrl_val = 64'({ctrl_div_reg, ctrl_en_reg});

    // Pre-update value of the selected register: the read data, and the base
    // for merging partial writes.
    always_comb begin
        sel_val = 64'h0;
        case (regsel)
            TIMER_MTIME:    sel_val = mtime_reg;
            TIMER_MTIMECMP: sel_val = mtimecmp_reg;
            TIMER_CTRL:     sel_val = ctrl_val;
            default:        sel_val = 64'h0;
        endcase
    end

    // Lane-mask generator: move right-aligned store data up to its byte offset
    // and replace only the lanes the access covers.
    assign wdata_shifted = bus.i_riscv_timer_wdata << {bus.i_riscv_timer_offset, 3'b000};
    assign wr_end        = lane_end(bus.i_riscv_timer_offset, bus.i_riscv_timer_size);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_sel[gi] = (4'(gi) >= {1'b0, bus.i_riscv_timer_offset}) && (4'(gi) < wr_end);
            assign wr_merged[gi*8 +: 8] = lane_sel[gi] ? wdata_shifted[gi*8 +: 8] : sel_val[gi*8 +: 8];
        end
    endgenerate

    // Writing mtime restarts the prescale period as well as ctrl writes.
    assign cnt_clear = wr_acc && ((regsel == TIMER_MTIME) || (regsel == TIMER_CTRL));

    riscv_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (i_riscv_timer_clk),
        .rst_n (i_riscv_timer_rst),
        .en    (ctrl_en_reg),
        .div   (ctrl_div_reg),
        .clear (cnt_clear),
        .tick  (tick)
    );

    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        ctrl_en_next  = ctrl_en_reg;
        ctrl_div_next = ctrl_div_reg;
        rdata_next    = rdata_reg;
        rvalid_next   = rvalid_reg;

        if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end

        // A port write to mtime overrides the increment on the same edge.
        if (wr_acc) begin
            case (regsel)
                TIMER_MTIME:    mtime_next = wr_merged;
                TIMER_MTIMECMP: mtimecmp_next = wr_merged;
                TIMER_CTRL: begin
                    ctrl_en_next  = wr_merged[CTRL_EN_BIT];
                    ctrl_div_next = wr_merged[CTRL_DIV_LSB +: PRESCALE_W];
                end
                default: ;
            endcase
        end

        // Read outputs freeze during a stall; otherwise rvalid is a one-cycle pulse.
        if (!i_riscv_timer_globstall) begin
            rvalid_next = rd_acc;
            if (rd_acc) begin
                rdata_next = sel_val;
            end
        end

        irq_next = (mtime_next >= mtimecmp_next);
    end

    always_ff @(posedge i_riscv_timer_clk or negedge i_riscv_timer_rst) begin
        if (!i_riscv_timer_rst) begin
            mtime_reg    <= MTIME_RST;
            mtimecmp_reg <= MTIMECMP_RST;
            ctrl_en_reg  <= CTRL_EN_RST;
            ctrl_div_reg <= '0;
            rdata_reg    <= 64'h0;
            rvalid_reg   <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            ctrl_en_reg  <= ctrl_en_next;
            ctrl_div_reg <= ctrl_div_next;
            rdata_reg    <= rdata_next;
            rvalid_reg   <= rvalid_next;
            irq_reg      <= irq_next;
        end
    end

    assign bus.o_riscv_timer_rdata  = rdata_reg;
    assign bus.o_riscv_timer_rvalid = rvalid_reg;
    assign o_riscv_timer_irq        = irq_reg;
    assign o_riscv_timer_mtime      = mtime_reg;

endmodule
